// File: rtl/jump_pkg.sv
// Shared types and constants for the jump-charge path. The states are
// READY/CHARGING/COOLDOWN. The scan-event payload carries decoded bytes from
// ps2_scan_decoder to press_timer.
package jump_pkg;

  localparam int unsigned PRESS_W = 4;

  localparam logic [7:0] SC_EXT           = 8'hE0;
  localparam logic [7:0] SC_BREAK         = 8'hF0;
  localparam logic [7:0] KEY_CODE_DEFAULT = 8'h29;

  typedef enum logic [1:0] {
    READY    = 2'd0,
    CHARGING = 2'd1,
    COOLDOWN = 2'd2
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [7:0] code;
    logic       is_break;
    logic       is_ext;
  } scan_event_t;

endpackage

// File: rtl/ps2_scan_decoder.sv
// Folds E0/F0 prefix bytes into flags. Every other byte produces a one-cycle
// registered event.
// Ports:
//   clk, rst      - clock, async active-high reset
//   kb_valid      - byte strobe
//   kb_data       - received scancode byte
//   event_o       - {valid, code, is_break, is_ext}, valid high for one cycle
module ps2_scan_decoder
  import jump_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output scan_event_t event_o
);

  logic        ext_q, ext_d;
  logic        brk_q, brk_d;
  scan_event_t ev_q, ev_d;

  // Prefix bytes only set flags; a terminating byte emits the event and clears them
  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    ev_d  = '0;
    if (kb_valid) begin
      if (kb_data == SC_EXT) begin
        ext_d = 1'b1;
      end else if (kb_data == SC_BREAK) begin
        brk_d = 1'b1;
      end else begin
        ev_d.valid    = 1'b1;
        ev_d.code     = kb_data;
        ev_d.is_break = brk_q;
        ev_d.is_ext   = ext_q;
        ext_d         = 1'b0;
        brk_d         = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      ev_q  <= '0;
    end else begin
      ext_q <= ext_d;
      brk_q <= brk_d;
      ev_q  <= ev_d;
    end
  end

  assign event_o = ev_q;

endmodule

// File: rtl/press_timer.sv
// Measures how long the jump key is held, in ticks. The count saturates at
// MAX_TIME and is latched at release, then further presses are locked out
// until the flight has finished.
// Ports:
//   clk, rst      - clock, async active-high reset
//   kb_valid      - scancode byte strobe
//   kb_data       - scancode byte
//   tick          - charge-rate enable
//   busy          - downstream flight still running
//   is_pressing   - high while charging
//   press_time    - live count while charging, held value afterwards
//   launch        - one-cycle pulse on release
module press_timer
  import jump_pkg::*;
#(
  parameter logic [7:0]  KEY_CODE    = KEY_CODE_DEFAULT,
  parameter int unsigned MAX_TIME    = 15,
  parameter int unsigned GUARD_TICKS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               kb_valid,
  input  logic [7:0]         kb_data,
  input  logic               tick,
  input  logic               busy,
  output logic               is_pressing,
  output logic [PRESS_W-1:0] press_time,
  output logic               launch
);

  localparam int unsigned GUARD_W = (GUARD_TICKS < 2) ? 1 : $clog2(GUARD_TICKS + 1);
  localparam logic [PRESS_W-1:0] MAX_Q   = PRESS_W'(MAX_TIME);
  localparam logic [GUARD_W-1:0] GUARD_Q = GUARD_W'(GUARD_TICKS);

  scan_event_t ev;
  logic        key_ev, make_ev, break_ev;

  state_e             state_q, state_d;
  logic [PRESS_W-1:0] press_q, press_d;
  logic [GUARD_W-1:0] guard_q, guard_d;
  logic               pressing_q, pressing_d;
  logic               launch_q, launch_d;

  ps2_scan_decoder u_dec (
    .clk      (clk),
    .rst      (rst),
    .kb_valid (kb_valid),
    .kb_data  (kb_data),
    .event_o  (ev)
  );

  // Extended codes never match, even when the low byte equals KEY_CODE
  assign key_ev   = ev.valid && (ev.code == KEY_CODE) && !ev.is_ext;
  assign make_ev  = key_ev && !ev.is_break;
  assign break_ev = key_ev && ev.is_break;

  // The count register doubles as press_time; a release wins over a same-cycle tick
  always_comb begin
    state_d  = state_q;
    press_d  = press_q;
    guard_d  = guard_q;
    launch_d = 1'b0;
    unique case (state_q)
      READY: begin
        if (make_ev && !busy) begin
          state_d = CHARGING;
          press_d = '0;
        end
      end
      CHARGING: begin
        if (break_ev) begin
          press_d  = (press_q == '0) ? PRESS_W'(1) : press_q;
          launch_d = 1'b1;
          guard_d  = '0;
          state_d  = COOLDOWN;
        end else if (tick && (press_q < MAX_Q)) begin
          press_d = press_q + PRESS_W'(1);
        end
      end
      COOLDOWN: begin
        if (tick && (guard_q < GUARD_Q)) begin
          guard_d = guard_q + GUARD_W'(1);
        end
        if ((guard_q == GUARD_Q) && !busy) begin
          state_d = READY;
        end
      end
      default: begin
        state_d = READY;
      end
    endcase
    pressing_d = (state_d == CHARGING);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= READY;
      press_q    <= '0;
      guard_q    <= '0;
      pressing_q <= 1'b0;
      launch_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      press_q    <= press_d;
      guard_q    <= guard_d;
      pressing_q <= pressing_d;
      launch_q   <= launch_d;
    end
  end

  assign is_pressing = pressing_q;
  assign press_time  = press_q;
  assign launch      = launch_q;

endmodule

// File: doc/press_timer.md
# press_timer

Converts PS/2 scancode bytes into the jump-charge control signals (`is_pressing`, `press_time`) consumed by the VGA game-display stage. It measures how long the jump key is held, saturates the measurement, and latches the result at release. It then locks out further presses until the ball's flight has finished. It sits directly between the keyboard receiver and the display/physics stage.

## Interface
Parameters:
- `KEY_CODE`, default 8'h29: non-extended make code of the jump key (space).
- `MAX_TIME`, default 15: saturation value of `press_time`; must be ≤ 15.
- `GUARD_TICKS`, default 2: minimum `tick` count spent in COOLDOWN before `busy` is trusted.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `kb_valid`, in, 1: single-cycle strobe; `kb_data` holds one received byte.
- `kb_data`, in, 8: PS/2 scancode byte.
- `tick`, in, 1: single-cycle charge-rate enable, synchronous to `clk` (the same rate as the display stage's `sclk`).
- `busy`, in, 1: high while the downstream flight countdown is non-zero.
- `is_pressing`, out, 1: high while charging.
- `press_time`, out, 4: charge value; live during charging, held after release.
- `launch`, out, 1: single-cycle pulse on the first `clk` after a valid release.

## Operation
**Scancode decode (per byte on `kb_valid`):**
- 8'hE0 sets `ext`.
- 8'hF0 sets `brk`.
- Any other byte emits an event `{code, brk, ext}` and clears both flags.
- Only events with `code == KEY_CODE` and `ext == 0` are relevant:
  - make: `brk == 0`.
  - break: `brk == 1`.

**State machine:** READY, CHARGING, COOLDOWN.
- **READY**
  - On a make event with `busy == 0`: go to CHARGING and clear the count to 0.
  - A make event with `busy == 1` is ignored.
  - Break events are ignored.
- **CHARGING**
  - `is_pressing = 1`.
  - Each `tick` increments the count, saturating at `MAX_TIME`.
  - Typematic repeat makes are ignored.
  - On a break event:
    - `press_time` is latched as max(count, 1).
    - `launch` is pulsed.
    - The state goes to COOLDOWN and the guard counter is cleared.
- **COOLDOWN**
  - `is_pressing = 0` and `press_time` is held.
  - The guard counter increments on `tick`, saturating at `GUARD_TICKS`.
  - When guard == `GUARD_TICKS` and `busy == 0`: go to READY. `press_time` keeps its value.
  - All key events are ignored.

**Simultaneous events:**
- `tick` and break in the same cycle in CHARGING: break wins and the tick is not counted.
- `tick` and make in the same cycle in READY: the count starts at 0 and the tick is not counted.

**Reset:**
- Every output is 0 (`is_pressing = 0`, `press_time = 0`, `launch = 0`).
- State is READY, and the decoder flags and counters are 0.
- An asserted `rst` mid-charge aborts with no `launch`.

## Timing
- Decoder: an event is registered 1 cycle after the terminating `kb_valid`.
- FSM transition and output update: 1 cycle after the event, so `is_pressing` rises 2 cycles after the make byte's `kb_valid`.
- Break byte at cycle N gives:
  - `is_pressing` falls at N+2.
  - `launch` is high exactly for cycle N+2.
  - `press_time` is final from N+2 onward.
- Count increments are visible on `press_time` the cycle after `tick`.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package `jump_pkg`:
  - state enum (READY/CHARGING/COOLDOWN).
  - constants `SC_EXT = 8'hE0` and `SC_BREAK = 8'hF0`.
  - default `KEY_CODE`.
- Sub-module `ps2_scan_decoder` holds the `ext`/`brk` flags and emits a one-cycle `{event_valid, code, is_break, is_ext}` event; `press_timer` instantiates it.

## Test plan
1. **Basic press.** Stimulus: after reset, send 29, then 5 ticks, then F0 29. Required: `is_pressing` high throughout, `press_time` steps 0→5, one `launch` pulse, `press_time` holds 5.
2. **Saturation and repeats.** Stimulus: make 29, 20 ticks, repeat 29 bytes in between, then break. Required: `press_time` saturates at 15 with no restart, and `launch` pulses once.
3. **Quick tap, extended key, other keys.** Stimulus: make then break with no tick. Required: `press_time` = 1. Then E0 29 and E0 F0 29 produce no response, and key 1C produces no response.
4. **Lockout.** Stimulus: after a launch, hold `busy` = 1 and send make 29. Required: ignored. Then drop `busy` after the guard ticks and send make 29. Required: `is_pressing` rises 2 cycles later.
5. **Collisions and reset.** Stimulus: break and `tick` in the same cycle at count 3. Required: `press_time` = 3. Stimulus: assert `rst` mid-charge. Required: all outputs 0 immediately, with no `launch`.
